reg_writeback_arbiter: RTL and testbench

Write-back stage that directly feeds the register file's single write port. It merges single-cycle ALU results with variable-latency results (loads, multiply/divide) onto that one port. ALU results take priority, and variable-latency results wait in a small in-order FIFO. It also exports a pending-write mask so the issue logic can stall on registers whose values are still queued.

---
 rtl/reg_writeback_arbiter.sv | 163 ++++++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU results win,
// variable-latency results queue in an in-order FIFO whose stale entries get squashed.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    input  logic [SEL_WIDTH-1:0]              alu_sel,
    input  logic [DATA_WIDTH-1:0]             alu_data,
    input  logic                              mem_valid,
    input  logic [SEL_WIDTH-1:0]              mem_sel,
    input  logic [DATA_WIDTH-1:0]             mem_data,
    output logic                              mem_ready,
    output logic                              out_write_en,
    output logic [SEL_WIDTH-1:0]              out_write_sel,
    output logic [DATA_WIDTH-1:0]             out_write_data,
    output logic [(2**SEL_WIDTH)-1:0]         out_pending,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   out_fifo_count
);

    localparam int NREG = 2**SEL_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [SEL_WIDTH-1:0]  sel_r  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_r;
    logic [FIFO_DEPTH-1:0] live_next_s;
    logic [PW-1:0]         head_r;
    logic [PW-1:0]         tail_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;

    logic                  alu_hit_s;
    logic                  mem_ready_s;
    logic                  push_acc_s;
    logic                  push_s;
    logic                  push_live_s;
    logic                  pop_s;
    logic [NREG-1:0]       pending_s;

    function automatic logic [NREG-1:0] sel_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[sel] = 1'b1;
        return v;
    endfunction

    // Handshake and arbitration decode; r0 targets count as no traffic at all.
    always_comb begin
        alu_hit_s   = alu_valid && (alu_sel != {SEL_WIDTH{1'b0}});
        mem_ready_s = !rst && (count_r < DEPTH_C);
        push_acc_s  = mem_valid && mem_ready_s;
        push_s      = push_acc_s && (mem_sel != {SEL_WIDTH{1'b0}});
        // A same-cycle ALU write to the same register is newer than this push.
        push_live_s = !(alu_hit_s && (alu_sel == mem_sel));
        pop_s       = !alu_hit_s && (count_r != {CW{1'b0}});
    end

    // Next live bits: squash by ALU destination, retire popped head, mark pushed tail.
    always_comb begin
        live_next_s = live_r;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_hit_s && (sel_r[i] == alu_sel)) begin
                live_next_s[i] = 1'b0;
            end else begin
                live_next_s[i] = live_r[i];
            end
        end
        if (pop_s) begin
            live_next_s[head_r] = 1'b0;
        end else begin
            live_next_s[head_r] = live_next_s[head_r];
        end
        if (push_s) begin
            live_next_s[tail_r] = push_live_s;
        end else begin
            live_next_s[tail_r] = live_next_s[tail_r];
        end
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Pending mask from live entries, forced clear while in reset.
    always_comb begin
        pending_s = {NREG{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_r[i]) begin
                pending_s = pending_s | sel_onehot(sel_r[i]);
            end else begin
                pending_s = pending_s;
            end
        end
        if (rst) begin
            pending_s = {NREG{1'b0}};
        end else begin
            pending_s[0] = 1'b0;
        end
    end

    // FIFO payload storage; contents are only meaningful under a live/occupied slot.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            sel_r[tail_r]  <= mem_sel;
            data_r[tail_r] <= mem_data;
        end
    end

    // FIFO control state: pointers, occupancy and live flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            live_r  <= {FIFO_DEPTH{1'b0}};
        end else begin
            live_r  <= live_next_s;
            count_r <= count_next_s;
            if (push_s) begin
                tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered write port; a squashed head still consumes its cycle with write_en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_write_en   <= 1'b0;
            out_write_sel  <= {SEL_WIDTH{1'b0}};
            out_write_data <= {DATA_WIDTH{1'b0}};
        end else if (alu_hit_s) begin
            out_write_en   <= 1'b1;
            out_write_sel  <= alu_sel;
            out_write_data <= alu_data;
        end else if (pop_s) begin
            out_write_en   <= live_r[head_r];
            out_write_sel  <= sel_r[head_r];
            out_write_data <= data_r[head_r];
        end else begin
            out_write_en   <= 1'b0;
        end
    end

    assign mem_ready      = mem_ready_s;
    assign out_pending    = pending_s;
    assign out_fifo_count = count_r;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: reset, ALU path, back-pressure,
// squash, same-cycle conflict, r0 drop, pointer wrap and mid-run reset.
module tb_reg_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_sel;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [3:0]  mem_sel;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        out_write_en;
    logic [3:0]  out_write_sel;
    logic [31:0] out_write_data;
    logic [15:0] out_pending;
    logic [2:0]  out_fifo_count;

    int n_cmp;
    int n_fail;

    reg_writeback_arbiter #(
        .DATA_WIDTH(32),
        .SEL_WIDTH (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_sel       (alu_sel),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_sel       (mem_sel),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .out_write_en  (out_write_en),
        .out_write_sel (out_write_sel),
        .out_write_data(out_write_data),
        .out_pending   (out_pending),
        .out_fifo_count(out_fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [3:0] sel,
                           input logic [31:0] data);
        chk({tag, ".en"},   32'(out_write_en),   32'(en));
        chk({tag, ".sel"},  32'(out_write_sel),  32'(sel));
        chk({tag, ".data"}, out_write_data,      data);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        alu_valid = 1'b0;
        alu_sel   = 4'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b1;
        mem_sel   = 4'd2;
        mem_data  = 32'hAAAA_0002;

        // Reset held two cycles with mem_valid asserted.
        tick();
        tick();
        chk("rst.ready", 32'(mem_ready), 32'd0);
        chk_out("rst.out", 1'b0, 4'd0, 32'd0);
        chk("rst.count", 32'(out_fifo_count), 32'd0);
        chk("rst.pending", 32'(out_pending), 32'd0);
        rst       = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("rel.ready", 32'(mem_ready), 32'd1);
        chk("rel.count", 32'(out_fifo_count), 32'd0);

        // ALU only.
        alu_valid = 1'b1;
        alu_sel   = 4'd3;
        alu_data  = 32'hDEAD_BEEF;
        tick();
        chk_out("alu", 1'b1, 4'd3, 32'hDEAD_BEEF);
        alu_valid = 1'b0;
        tick();
        chk_out("alu.idle", 1'b0, 4'd3, 32'hDEAD_BEEF);

        // Fill under continuous ALU traffic.
        for (int k = 1; k <= 4; k++) begin
            alu_valid = 1'b1;
            alu_sel   = 4'd5;
            alu_data  = 32'h50 + 32'(k);
            mem_valid = 1'b1;
            mem_sel   = 4'(k);
            mem_data  = 32'h100 + 32'(k);
            tick();
            chk_out("fill.alu", 1'b1, 4'd5, 32'h50 + 32'(k));
            chk("fill.count", 32'(out_fifo_count), 32'(k));
        end
        chk("full.ready", 32'(mem_ready), 32'd0);
        chk("full.pending", 32'(out_pending), 32'h001E);
        mem_sel  = 4'd6;
        mem_data = 32'h106;
        alu_data = 32'h55;
        tick();
        chk("full.ignore.count", 32'(out_fifo_count), 32'd4);
        chk("full.ignore.pending", 32'(out_pending), 32'h001E);

        // Drain in order once ALU traffic stops.
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out("drain", 1'b1, 4'(k), 32'h100 + 32'(k));
            chk("drain.count", 32'(out_fifo_count), 32'(4 - k));
            chk("drain.ready", 32'(mem_ready), 32'd1);
            chk("drain.pending", 32'(out_pending), (32'h001E >> (k + 1)) << (k + 1));
        end

        // Squash of a queued entry by a later ALU write.
        mem_valid = 1'b1;
        mem_sel   = 4'd7;
        mem_data  = 32'h11;
        tick();
        chk("sq.push.count", 32'(out_fifo_count), 32'd1);
        chk("sq.push.pending", 32'(out_pending), 32'h0080);
        chk("sq.push.en", 32'(out_write_en), 32'd0);
        mem_valid = 1'b0;
        alu_valid = 1'b1;
        alu_sel   = 4'd7;
        alu_data  = 32'h22;
        tick();
        chk_out("sq.alu", 1'b1, 4'd7, 32'h22);
        chk("sq.pending", 32'(out_pending), 32'd0);
        chk("sq.count", 32'(out_fifo_count), 32'd1);
        alu_valid = 1'b0;
        tick();
        chk("sq.pop.en", 32'(out_write_en), 32'd0);
        chk("sq.pop.count", 32'(out_fifo_count), 32'd0);

        // Same-cycle conflict on r9.
        mem_valid = 1'b1;
        mem_sel   = 4'd9;
        mem_data  = 32'h33;
        alu_valid = 1'b1;
        alu_sel   = 4'd9;
        alu_data  = 32'h22;
        tick();
        chk_out("conf.alu", 1'b1, 4'd9, 32'h22);
        chk("conf.count", 32'(out_fifo_count), 32'd1);
        chk("conf.pending", 32'(out_pending), 32'd0);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        tick();
        chk("conf.pop.en", 32'(out_write_en), 32'd0);
        chk("conf.pop.count", 32'(out_fifo_count), 32'd0);

        // Push to r0 is accepted and dropped.
        mem_valid = 1'b1;
        mem_sel   = 4'd0;
        mem_data  = 32'h44;
        tick();
        chk("r0.count", 32'(out_fifo_count), 32'd0);
        chk("r0.en", 32'(out_write_en), 32'd0);
        chk("r0.pending", 32'(out_pending), 32'd0);

        // Ten back-to-back pushes with overlapping pops wrap the pointers.
        for (int i = 0; i < 10; i++) begin
            mem_valid = 1'b1;
            mem_sel   = 4'(i + 1);
            mem_data  = 32'h200 + 32'(i);
            tick();
            chk("wrap.count", 32'(out_fifo_count), 32'd1);
            chk("wrap.pending", 32'(out_pending), 32'd1 << (i + 1));
            if (i == 0) begin
                chk("wrap.first.en", 32'(out_write_en), 32'd0);
            end else begin
                chk_out("wrap.pop", 1'b1, 4'(i), 32'h200 + 32'(i - 1));
            end
        end
        // Last pop happens alongside an ALU request to r0, which must not block it.
        mem_valid = 1'b0;
        alu_valid = 1'b1;
        alu_sel   = 4'd0;
        alu_data  = 32'hFFFF_FFFF;
        tick();
        chk_out("wrap.last", 1'b1, 4'd10, 32'h209);
        chk("wrap.end.count", 32'(out_fifo_count), 32'd0);
        chk("wrap.end.pending", 32'(out_pending), 32'd0);

        // Mid-run reset discards a queued entry and gates ready/pending at once.
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        mem_sel   = 4'd5;
        mem_data  = 32'h77;
        tick();
        chk("mid.pending", 32'(out_pending), 32'h0020);
        mem_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid.rst.ready", 32'(mem_ready), 32'd0);
        chk("mid.rst.pending", 32'(out_pending), 32'd0);
        tick();
        chk_out("mid.rst.out", 1'b0, 4'd0, 32'd0);
        chk("mid.rst.count", 32'(out_fifo_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("mid.rel.ready", 32'(mem_ready), 32'd1);
        chk("mid.rel.en", 32'(out_write_en), 32'd0);
        chk("mid.rel.pending", 32'(out_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
